// File: rtl/alu_cmd_decoder.sv
// ---------------------------------------------------------------------------
// alu_cmd_decoder
//   Registered decode stage between instruction fetch and the execute-stage
//   ALU. Each accepted 32-bit instruction is translated into a 4-bit ALU
//   command plus operand-select, writeback and memory-control fields. These
//   are held in a single-entry output register with valid/ready handshakes on
//   both sides. Read-after-write hazards against in-flight destinations stall
//   the input, and a flush discards the held entry and the incoming one.
//
// Ports
//   clk, rst_n            rising-edge clock, synchronous active-low reset
//   in_valid/in_ready     fetch-side handshake
//   in_instr              [31:26] opcode, [25:21] rd, [20:16] rs1,
//                         [15:11] rs2, [15:0] imm16
//   flush                 drop the held entry and the incoming instruction
//   exe_wb_en/exe_dest    destination written by the EXE stage
//   mem_wb_en/mem_dest    destination written by the MEM stage
//   out_valid/out_ready   execute-side handshake
//   out_cmd..out_mem_wr   decoded entry
//   illegal_pulse         one cycle after an illegal opcode is accepted
//   illegal_count         saturating count of accepted illegal opcodes
// ---------------------------------------------------------------------------
module alu_cmd_decoder #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_instr,
    output logic              in_ready,
    input  logic              flush,
    input  logic              exe_wb_en,
    input  logic [4:0]        exe_dest,
    input  logic              mem_wb_en,
    input  logic [4:0]        mem_dest,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [3:0]        out_cmd,
    output logic [4:0]        out_rd,
    output logic [4:0]        out_src1,
    output logic [4:0]        out_src2,
    output logic [DATA_W-1:0] out_imm,
    output logic              out_imm_sel,
    output logic              out_wb_en,
    output logic              out_mem_rd,
    output logic              out_mem_wr,
    output logic              illegal_pulse,
    output logic [CNT_W-1:0]  illegal_count
);

    // Field extraction
    logic [5:0]        w_opcode;
    logic [4:0]        w_rd;
    logic [4:0]        w_rs1;
    logic [4:0]        w_rs2;
    logic [DATA_W-1:0] w_imm;

    assign w_opcode = in_instr[31:26];
    assign w_rd     = in_instr[25:21];
    assign w_rs1    = in_instr[20:16];
    assign w_rs2    = in_instr[15:11];
    assign w_imm    = {{(DATA_W-16){in_instr[15]}}, in_instr[15:0]};

    // Decoded fields for the instruction on in_instr
    logic [3:0] w_cmd;
    logic       w_wb_raw;
    logic       w_imm_sel;
    logic       w_mem_rd;
    logic       w_mem_wr;
    logic       w_use1;
    logic       w_use2;
    logic       w_src2_is_rd;
    logic       w_illegal;
    logic [4:0] w_src2;
    logic       w_wb_en;

    always_comb begin
        w_cmd        = 4'b0000;
        w_wb_raw     = 1'b0;
        w_imm_sel    = 1'b0;
        w_mem_rd     = 1'b0;
        w_mem_wr     = 1'b0;
        w_use1       = 1'b0;
        w_use2       = 1'b0;
        w_src2_is_rd = 1'b0;
        w_illegal    = 1'b0;
        case (w_opcode)
            6'h00: ;
            6'h01: begin w_cmd = 4'b0000; w_wb_raw = 1'b1; w_use1 = 1'b1; w_use2 = 1'b1; end
            6'h02: begin w_cmd = 4'b0010; w_wb_raw = 1'b1; w_use1 = 1'b1; w_use2 = 1'b1; end
            6'h03: begin w_cmd = 4'b0100; w_wb_raw = 1'b1; w_use1 = 1'b1; w_use2 = 1'b1; end
            6'h04: begin w_cmd = 4'b0101; w_wb_raw = 1'b1; w_use1 = 1'b1; w_use2 = 1'b1; end
            6'h05: begin w_cmd = 4'b0110; w_wb_raw = 1'b1; w_use1 = 1'b1; w_use2 = 1'b1; end
            6'h06: begin w_cmd = 4'b0111; w_wb_raw = 1'b1; w_use1 = 1'b1; w_use2 = 1'b1; end
            6'h07: begin w_cmd = 4'b1000; w_wb_raw = 1'b1; w_use1 = 1'b1; w_use2 = 1'b1; end
            6'h08: begin w_cmd = 4'b1001; w_wb_raw = 1'b1; w_use1 = 1'b1; w_use2 = 1'b1; end
            6'h09: begin w_cmd = 4'b1010; w_wb_raw = 1'b1; w_use1 = 1'b1; w_use2 = 1'b1; end
            6'h0A: begin w_cmd = 4'b1100; w_wb_raw = 1'b1; w_use2 = 1'b1; end
            6'h0B: begin w_cmd = 4'b1101; w_wb_raw = 1'b1; w_use1 = 1'b1; end
            6'h20: begin w_wb_raw = 1'b1; w_imm_sel = 1'b1; w_use1 = 1'b1; end
            6'h21: begin w_wb_raw = 1'b1; w_imm_sel = 1'b1; w_mem_rd = 1'b1; w_use1 = 1'b1; end
            // Store reads rd as its data register, so rd doubles as source 2
            6'h22: begin
                w_imm_sel    = 1'b1;
                w_mem_wr     = 1'b1;
                w_use1       = 1'b1;
                w_use2       = 1'b1;
                w_src2_is_rd = 1'b1;
            end
            default: w_illegal = 1'b1;   // decodes as NOP
        endcase
    end

    assign w_src2  = w_src2_is_rd ? w_rd : w_rs2;
    assign w_wb_en = w_wb_raw && (w_rd != 5'd0);

    // Output register
    logic              r_valid;
    logic [3:0]        r_cmd;
    logic [4:0]        r_rd;
    logic [4:0]        r_src1;
    logic [4:0]        r_src2;
    logic [DATA_W-1:0] r_imm;
    logic              r_imm_sel;
    logic              r_wb_en;
    logic              r_mem_rd;
    logic              r_mem_wr;
    logic              r_pulse;
    logic [CNT_W-1:0]  r_count;

    // The held entry stops being a hazard in the cycle it is consumed
    logic w_leaving;
    assign w_leaving = r_valid && out_ready;

    function automatic logic src_hazard(
        input logic [4:0] s,
        input logic       exe_en,
        input logic [4:0] exe_d,
        input logic       mem_en,
        input logic [4:0] mem_d,
        input logic       held_wb,
        input logic [4:0] held_rd
    );
        return (s != 5'd0) &&
               ((exe_en && (exe_d == s)) ||
                (mem_en && (mem_d == s)) ||
                (held_wb && (held_rd == s)));
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    logic w_held_wb;
    logic w_hazard;
    logic w_accept;

    assign w_held_wb = r_valid && r_wb_en && !w_leaving;
    assign w_hazard  =
        (w_use1 && src_hazard(w_rs1,  exe_wb_en, exe_dest, mem_wb_en, mem_dest, w_held_wb, r_rd)) ||
        (w_use2 && src_hazard(w_src2, exe_wb_en, exe_dest, mem_wb_en, mem_dest, w_held_wb, r_rd));

    assign in_ready = flush || (!w_hazard && (!r_valid || out_ready));
    assign w_accept = in_valid && in_ready && !flush;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid   <= 1'b0;
            r_cmd     <= '0;
            r_rd      <= '0;
            r_src1    <= '0;
            r_src2    <= '0;
            r_imm     <= '0;
            r_imm_sel <= 1'b0;
            r_wb_en   <= 1'b0;
            r_mem_rd  <= 1'b0;
            r_mem_wr  <= 1'b0;
            r_pulse   <= 1'b0;
            r_count   <= '0;
        end else begin
            r_pulse <= 1'b0;
            if (flush) begin
                r_valid <= 1'b0;
            end else if (w_accept) begin
                r_valid   <= 1'b1;
                r_cmd     <= w_cmd;
                r_rd      <= w_rd;
                r_src1    <= w_rs1;
                r_src2    <= w_src2;
                r_imm     <= w_imm;
                r_imm_sel <= w_imm_sel;
                r_wb_en   <= w_wb_en;
                r_mem_rd  <= w_mem_rd;
                r_mem_wr  <= w_mem_wr;
                if (w_illegal) begin
                    r_pulse <= 1'b1;
                    r_count <= sat_inc(r_count);
                end
            end else if (w_leaving) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign out_valid     = r_valid;
    assign out_cmd       = r_cmd;
    assign out_rd        = r_rd;
    assign out_src1      = r_src1;
    assign out_src2      = r_src2;
    assign out_imm       = r_imm;
    assign out_imm_sel   = r_imm_sel;
    assign out_wb_en     = r_wb_en;
    assign out_mem_rd    = r_mem_rd;
    assign out_mem_wr    = r_mem_wr;
    assign illegal_pulse = r_pulse;
    assign illegal_count = r_count;

endmodule
